main_fsm: RTL

MAIN_FSM -- requirements
Module: main_fsm

---
 rtl/main_fsm_pkg.sv | 148 ++++++++++++++
 rtl/main_fsm.sv | 123 ++++++++++++
 2 files changed

// File: rtl/main_fsm_pkg.sv
// main_fsm_pkg -- shared encodings for the multi-cycle control FSM.
// Holds the 4-bit state enumeration, the opcode constants, the datapath
// select / ALUOp encodings (also consumed by the ALU decoder) and a helper
// that maps a state to its Moore control word.
// Optional feature macro: MAIN_FSM_ILLEGAL_TRAP_EN (adds the illegal_op bit).
package main_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        // Unknown-opcode state: a sticky trap when the trap feature is
        // built in, otherwise a one-cycle "instruction retired" step.
        S_TRAP     = 4'd11
    } state_e;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    typedef struct packed {
        logic       adr_src;
        logic       ir_write;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic       mem_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
        logic       instr_done;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
        logic       illegal_op;
`endif
    } ctrl_t;

    // Moore control word for a state; anything not named here stays 0.
    function automatic ctrl_t ctrl_for_state(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.adr_src    = 1'b0;
                c.ir_write   = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALURESULT;
                c.pc_update  = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                c.result_src = RES_ALUOUT;
                c.adr_src    = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                c.result_src = RES_ALUOUT;
                c.adr_src    = 1'b1;
                c.mem_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_RD2;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a  = SRCA_RD1;
                c.alu_src_b  = SRCB_RD2;
                c.alu_op     = ALUOP_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
                c.instr_done = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALUOUT;
                c.pc_update  = 1'b1;
            end
            S_TRAP: begin
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
                c.illegal_op = 1'b1;
`else
                c.instr_done = 1'b1;
`endif
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/main_fsm.sv
// main_fsm -- Moore control FSM of a multi-cycle RISC-V style core.
// The control word is registered alongside the state (decoded from the
// next state), so no path exists from op to any output. Reset masks every
// output to 0 and shows FETCH on state_dbg while it is held high.
// Optional feature macro: MAIN_FSM_ILLEGAL_TRAP_EN -- unknown opcodes lock
// into TRAP with illegal_op=1 until reset; when undefined they retire in
// one extra cycle with instr_done=1 and return to FETCH.
module main_fsm
    import main_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUOp,
    output logic       instr_done,
    output logic [3:0] state_dbg
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    ,
    output logic       illegal_op
`endif
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl_d;
    ctrl_t  ctrl_out_s;
    state_e state_out_s;

    // Next-state rules; op is only consulted in DECODE and MEMADR.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_ITYPE:     state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW) begin
                    state_d = S_MEMREAD;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_TRAP: begin
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
                state_d = S_TRAP;
`else
                state_d = S_FETCH;
`endif
            end
            default:    state_d = S_FETCH;
        endcase
    end

    // Control word that will belong to the state being entered.
    always_comb begin
        ctrl_d = ctrl_for_state(state_d);
    end

    // State register and registered control word, synchronous reset to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= ctrl_for_state(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Reset holds every output quiet and reports FETCH for debug.
    always_comb begin
        if (reset) begin
            ctrl_out_s  = '0;
            state_out_s = S_FETCH;
        end else begin
            ctrl_out_s  = ctrl_q;
            state_out_s = state_q;
        end
    end

    assign AdrSrc     = ctrl_out_s.adr_src;
    assign IRWrite    = ctrl_out_s.ir_write;
    assign PCUpdate   = ctrl_out_s.pc_update;
    assign Branch     = ctrl_out_s.branch;
    assign RegWrite   = ctrl_out_s.reg_write;
    assign MemWrite   = ctrl_out_s.mem_write;
    assign ALUSrcA    = ctrl_out_s.alu_src_a;
    assign ALUSrcB    = ctrl_out_s.alu_src_b;
    assign ResultSrc  = ctrl_out_s.result_src;
    assign ALUOp      = ctrl_out_s.alu_op;
    assign instr_done = ctrl_out_s.instr_done;
    assign state_dbg  = state_out_s;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    assign illegal_op = ctrl_out_s.illegal_op;
`endif

endmodule
